// File: rtl/rc5_key_expand.sv
// RC5-16 key-schedule engine: fills S[0..2r+1] from a byte key with one mixing iteration per clock.
// Optional RC5_KEY_ZEROIZE_EN adds a ZERO state that wipes L, A, B and the latched key after mixing.
module rc5_key_expand #(
    parameter int unsigned W             = 16,
    parameter int unsigned KEY_BYTES_MAX = 16,
    parameter int unsigned MAX_SUBKEYS   = 34,
    parameter logic [W-1:0] P_CONST      = 16'hB7E1,
    parameter logic [W-1:0] Q_CONST      = 16'h9E37
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [4:0]                 num_rounds,
    input  logic [4:0]                 key_len,
    input  logic [8*KEY_BYTES_MAX-1:0] key,
    output logic [W-1:0]               subkeys [0:MAX_SUBKEYS-1],
    output logic                       subkeys_valid,
    output logic                       busy,
    output logic                       done
);

    // state | meaning
    // IDLE  | waiting for start, table held
    // LOAD  | copy masked key into L, clear table
    // INIT  | S[k] = P + k*Q, one entry per cycle
    // MIX   | one key-mixing iteration per cycle
    // ZERO  | wipe L/A/B/key (RC5_KEY_ZEROIZE_EN only)
    // DONE  | done pulse, table marked valid
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        INIT,
        MIX,
`ifdef RC5_KEY_ZEROIZE_EN
        ZERO,
`endif
        DONE
    } state_t;

    localparam int unsigned L_WORDS = KEY_BYTES_MAX / 2;

    state_t                     state;
    logic [W-1:0]               l_mem [0:L_WORDS-1];
    logic [W-1:0]               a_reg, b_reg, q_sum;
    logic [5:0]                 i_idx, t_reg;
    logic [2:0]                 j_idx;
    logic [3:0]                 c_reg;
    logic [6:0]                 iter, m_reg;
    logic [4:0]                 b_len;
    logic [8*KEY_BYTES_MAX-1:0] key_lat;

    logic [4:0]                 r_clamp, b_clamp;
    logic [5:0]                 t_next, tc_max;
    logic [3:0]                 c_next;
    logic [6:0]                 m_next;
    logic [8*KEY_BYTES_MAX-1:0] key_masked;
    logic [W-1:0]               mix_sum, a_new, ab_sum, b_new;

    // Rotate through a doubled word so an amount of 0 needs no special case.
    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input logic [3:0] n);
        logic [2*W-1:0] dbl;
        dbl = {v, v} << n;
        return dbl[2*W-1:W];
    endfunction

    always_comb begin
        r_clamp = (num_rounds > 5'd16) ? 5'd16 : num_rounds;
        b_clamp = (key_len > 5'd16) ? 5'd16 : key_len;
        t_next  = {r_clamp, 1'b0} + 6'd2;
        c_next  = (b_clamp == 5'd0) ? 4'd1 : 4'((b_clamp + 5'd1) >> 1);
        tc_max  = (t_next > {2'b00, c_next}) ? t_next : {2'b00, c_next};
        m_next  = {1'b0, tc_max} + {tc_max, 1'b0};
    end

    always_comb begin
        key_masked = '0;
        for (int k = 0; k < KEY_BYTES_MAX; k++) begin
            if (5'(k) < b_len) key_masked[8*k +: 8] = key_lat[8*k +: 8];
        end
    end

    always_comb begin
        mix_sum = subkeys[i_idx] + a_reg + b_reg;
        a_new   = rotl(mix_sum, 4'd3);
        ab_sum  = a_new + b_reg;
        b_new   = rotl(l_mem[j_idx] + ab_sum, ab_sum[3:0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            for (int n = 0; n < MAX_SUBKEYS; n++) subkeys[n] <= '0;
            for (int n = 0; n < L_WORDS; n++) l_mem[n] <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            q_sum         <= '0;
            i_idx         <= '0;
            j_idx         <= '0;
            iter          <= '0;
            t_reg         <= '0;
            c_reg         <= '0;
            m_reg         <= '0;
            b_len         <= '0;
            key_lat       <= '0;
            subkeys_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        t_reg         <= t_next;
                        c_reg         <= c_next;
                        m_reg         <= m_next;
                        b_len         <= b_clamp;
                        key_lat       <= key;
                        subkeys_valid <= 1'b0;
                        busy          <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    for (int n = 0; n < L_WORDS; n++) l_mem[n] <= key_masked[16*n +: 16];
                    for (int n = 0; n < MAX_SUBKEYS; n++) subkeys[n] <= '0;
                    subkeys_valid <= 1'b0;
                    a_reg         <= '0;
                    b_reg         <= '0;
                    i_idx         <= '0;
                    q_sum         <= P_CONST;
                    state         <= INIT;
                end
                INIT: begin
                    subkeys[i_idx] <= q_sum;
                    q_sum          <= q_sum + Q_CONST;
                    if (i_idx == t_reg - 6'd1) begin
                        i_idx <= '0;
                        j_idx <= '0;
                        iter  <= '0;
                        state <= MIX;
                    end else begin
                        i_idx <= i_idx + 6'd1;
                    end
                end
                MIX: begin
                    subkeys[i_idx] <= a_new;
                    l_mem[j_idx]   <= b_new;
                    a_reg          <= a_new;
                    b_reg          <= b_new;
                    i_idx          <= (i_idx == t_reg - 6'd1) ? 6'd0 : i_idx + 6'd1;
                    j_idx          <= ({1'b0, j_idx} == c_reg - 4'd1) ? 3'd0 : j_idx + 3'd1;
                    iter           <= iter + 7'd1;
                    if (iter == m_reg - 7'd1) begin
`ifdef RC5_KEY_ZEROIZE_EN
                        state <= ZERO;
`else
                        state <= DONE;
                        done  <= 1'b1;
`endif
                    end
                end
`ifdef RC5_KEY_ZEROIZE_EN
                ZERO: begin
                    for (int n = 0; n < L_WORDS; n++) l_mem[n] <= '0;
                    a_reg   <= '0;
                    b_reg   <= '0;
                    key_lat <= '0;
                    done    <= 1'b1;
                    state   <= DONE;
                end
`endif
                DONE: begin
                    subkeys_valid <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_key_expand.sv
// Directed bench for rc5_key_expand: hand-derived latencies and S[0..1] for the all-zero key,
// plus a textbook software RC5-16 key schedule as the reference for full tables.
module tb_rc5_key_expand;

`ifdef RC5_KEY_ZEROIZE_EN
    localparam int ZX = 1;
`else
    localparam int ZX = 0;
`endif

    localparam logic [127:0] K1 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] K2 = 128'h915F4619BE41B2516355A50110A9C391;

    logic         clk;
    logic         rst;
    logic         start;
    logic [4:0]   num_rounds;
    logic [4:0]   key_len;
    logic [127:0] key;
    logic [15:0]  subkeys [0:33];
    logic         subkeys_valid;
    logic         busy;
    logic         done;

    int           n_vec = 0;
    int           n_err = 0;
    logic [15:0]  exp_s [0:33];
    logic [15:0]  ref16 [0:33];

    rc5_key_expand dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_rounds    (num_rounds),
        .key_len       (key_len),
        .key           (key),
        .subkeys       (subkeys),
        .subkeys_valid (subkeys_valid),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] rotl16(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    // Plain software RC5-16 key expansion into exp_s.
    function automatic void model(input int r, input int b, input logic [127:0] k);
        logic [15:0] l [0:7];
        logic [15:0] a, bv, x;
        int rr, bl, t, c, m, ii, jj;
        rr = (r > 16) ? 16 : r;
        bl = (b > 16) ? 16 : b;
        t  = 2 * rr + 2;
        c  = (bl == 0) ? 1 : (bl + 1) / 2;
        m  = 3 * ((t > c) ? t : c);
        for (int n = 0; n < 34; n++) exp_s[n] = 16'h0;
        for (int n = 0; n < 8; n++) l[n] = 16'h0;
        for (int n = 0; n < bl; n++) l[n/2][8*(n%2) +: 8] = k[8*n +: 8];
        exp_s[0] = 16'hB7E1;
        for (int n = 1; n < t; n++) exp_s[n] = exp_s[n-1] + 16'h9E37;
        a = 0; bv = 0; ii = 0; jj = 0;
        for (int n = 0; n < m; n++) begin
            x         = exp_s[ii] + a + bv;
            a         = rotl16(x, 3);
            exp_s[ii] = a;
            x         = a + bv;
            bv        = rotl16(l[jj] + x, int'(x[3:0]));
            l[jj]     = bv;
            ii        = (ii + 1) % t;
            jj        = (jj + 1) % c;
        end
    endfunction

    task automatic run(input string name, input int r, input int b, input logic [127:0] k,
                       input int exp_lat, input bit hammer);
        int cyc, busy_low, valid_hi, extra;
        bit seen;
        model(r, b, k);
        @(negedge clk);
        num_rounds = 5'(r);
        key_len    = 5'(b);
        key        = k;
        start      = 1'b1;
        @(posedge clk); #1;
        if (!hammer) start = 1'b0;
        cyc = 1; seen = 0; busy_low = 0; valid_hi = 0;
        while (!seen && cyc < 400) begin
            if (busy !== 1'b1) busy_low++;
            if (subkeys_valid !== 1'b0) valid_hi++;
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                if (hammer) begin
                    num_rounds = 5'($urandom_range(0, 31));
                    key_len    = 5'($urandom_range(0, 31));
                    key        = {$urandom(), $urandom(), $urandom(), $urandom()};
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        chk({name, " done latency"}, 32'(cyc), 32'(exp_lat));
        chk({name, " busy gaps"}, 32'(busy_low), 32'd0);
        chk({name, " early valid"}, 32'(valid_hi), 32'd0);
        @(posedge clk); #1;
        chk({name, " valid after done"}, {31'd0, subkeys_valid}, 32'd1);
        chk({name, " busy after done"}, {31'd0, busy}, 32'd0);
        chk({name, " done width"}, {31'd0, done}, 32'd0);
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1 || subkeys_valid !== 1'b1) extra++;
        end
        chk({name, " idle hold"}, 32'(extra), 32'd0);
        for (int n = 0; n < 34; n++)
            chk($sformatf("%s S[%0d]", name, n), {16'd0, subkeys[n]}, {16'd0, exp_s[n]});
    endtask

    initial begin
        int cyc;
        rst = 1'b0; start = 1'b0; num_rounds = '0; key_len = '0; key = '0;
        #12;
        chk("reset valid", {31'd0, subkeys_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset S[0]", {16'd0, subkeys[0]}, 32'd0);
        chk("reset S[33]", {16'd0, subkeys[33]}, 32'd0);
        @(negedge clk); rst = 1'b1;

        // Zero key, r=0: S[0..1] worked through by hand.
        run("r0b0", 0, 0, 128'h0, 10 + ZX, 1'b0);
        chk("r0b0 hand S[0]", {16'd0, subkeys[0]}, 32'h7865);
        chk("r0b0 hand S[1]", {16'd0, subkeys[1]}, 32'h33F4);
        for (int n = 2; n < 34; n++)
            chk($sformatf("r0b0 zero S[%0d]", n), {16'd0, subkeys[n]}, 32'd0);

        run("r12b16", 12, 16, K1, 106 + ZX, 1'b0);
        for (int n = 26; n < 34; n++)
            chk($sformatf("r12b16 zero S[%0d]", n), {16'd0, subkeys[n]}, 32'd0);

        run("r16b16", 16, 16, K2, 138 + ZX, 1'b0);
        for (int n = 0; n < 34; n++) ref16[n] = exp_s[n];
        run("r16b5", 16, 5, K2, 138 + ZX, 1'b0);
        run("r20b31", 20, 31, K2, 138 + ZX, 1'b0);
        for (int n = 0; n < 34; n++)
            chk($sformatf("clamp S[%0d]", n), {16'd0, subkeys[n]}, {16'd0, ref16[n]});

        run("hammer r3b7", 3, 7, K1, 34 + ZX, 1'b1);

        // Reset at cycle 40 of an r=12 run.
        @(negedge clk);
        num_rounds = 5'd12; key_len = 5'd16; key = K1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid-reset valid", {31'd0, subkeys_valid}, 32'd0);
        chk("mid-reset busy", {31'd0, busy}, 32'd0);
        chk("mid-reset done", {31'd0, done}, 32'd0);
        chk("mid-reset S[0]", {16'd0, subkeys[0]}, 32'd0);
        chk("mid-reset S[5]", {16'd0, subkeys[5]}, 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("post-reset valid", {31'd0, subkeys_valid}, 32'd0);
        run("restart r12b16", 12, 16, K1, 106 + ZX, 1'b0);
`ifdef RC5_KEY_ZEROIZE_EN
        chk("zeroize A", {16'd0, dut.a_reg}, 32'd0);
        chk("zeroize B", {16'd0, dut.b_reg}, 32'd0);
        chk("zeroize L[0]", {16'd0, dut.l_mem[0]}, 32'd0);
        chk("zeroize L[7]", {16'd0, dut.l_mem[7]}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rc5_key_expand.md
Name: rc5_key_expand

Overview:
RC5-16 key-schedule engine that produces the expanded subkey table S[0..33] consumed by the round datapath. It is the writer side of the subkeys interface. It takes a user key of up to 16 bytes and a round count, then runs the standard RC5 expansion: P16/Q16 initialisation followed by 3*max(t,c) mixing iterations, one iteration per clock. When finished, it presents a stable subkey table and a done pulse.

Parameters:
W, 16, word width in bits (fixed RC5-16; other values unsupported)
KEY_BYTES_MAX, 16, maximum key length in bytes
MAX_SUBKEYS, 34, subkey table depth, equal to 2*(16+1)
P_CONST, 16'hB7E1, RC5 magic constant P16
Q_CONST, 16'h9E37, RC5 magic constant Q16

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  begin expansion; sampled only in IDLE
num_rounds  in  5  round count r, not 0-indexed; values above 16 are clamped to 16
key_len  in  5  key length b in bytes; values above 16 are clamped to 16
key  in  128  key bytes; byte k = key[8k+7:8k]
subkeys  out  16 x [0:33]  expanded table S
subkeys_valid  out  1  table complete and stable
busy  out  1  expansion in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst=0): state=IDLE; all subkeys=0; L[0..7]=0; A=B=0; i=j=iter=0; subkeys_valid=0; busy=0; done=0.
- Derived values, latched on start:
  - t = 2*r+2, giving a range of 2..34.
  - c = max(1, ceil(b/2)), giving a range of 1..8.
  - m = 3*max(t,c).
- State IDLE: busy=0. When start=1, latch r, b, key and go to LOAD.
- State LOAD (1 cycle):
  - L[j] = key[16j+15:16j], with every byte at index >= b forced to 0.
  - subkeys[0..33] cleared to 0; subkeys_valid=0.
  - A=B=0; i=0; go to INIT.
- State INIT (t cycles):
  - Cycle k writes S[k]=P_CONST+k*Q_CONST (mod 2^16), computed as a running sum.
  - Entries >= t remain 0.
  - After k=t-1, go to MIX with i=j=iter=0.
- State MIX (m cycles), one iteration per cycle, all arithmetic mod 2^16:
  - A' = rotl(S[i]+A+B, 3); S[i] <= A'.
  - B' = rotl(L[j]+A'+B, (A'+B)[3:0]); L[j] <= B'.
  - A<=A'; B<=B'.
  - i wraps modulo t; j wraps modulo c.
  - When iter=m-1, go to DONE.
- State DONE (1 cycle): done=1, subkeys_valid<=1, then return to IDLE.
- Latency: with start sampled at cycle 0, LOAD is at cycle 1 and done=1 at cycle t+2+m.
- busy=1 in every state except IDLE.
- start while busy: ignored. Latched inputs are unaffected by input changes mid-run.
- subkeys holds its value in IDLE indefinitely. subkeys_valid stays 1 until the next accepted start.
- subkeys_valid drops in the LOAD cycle, so the datapath must not start while it is 0.
- Reset mid-operation: immediate return to reset values. No partial table is ever flagged valid.
- Rotation amount uses only the low 4 bits of A'+B; an amount of 0 means no rotate.

Optional Feature:
RC5_KEY_ZEROIZE_EN
- Defined:
  - An extra ZERO state is inserted between MIX and DONE.
  - In ZERO, L[0..7], A, B and the latched key are cleared to 0 in a single cycle.
  - Latency becomes t+3+m.
- Undefined: no ZERO state. L, A and B retain their final mix values until the next LOAD or reset.

Test Plan:
- Reset, then start with r=0, b=0, key=0: done at cycle 2+2+6=10; subkeys[2..33]=0; subkeys[0..1] match the software RC5-16 model; busy high for cycles 1..10.
- r=12, b=16, key=128'h0F0E0D0C0B0A09080706050403020100: done at cycle 28+78=106; S[0..25] match the model; S[26..33]=0.
- r=16, b=16 then r=16, b=5 with the same key: t=34 in both runs; c=8 vs c=3; upper key bytes 5..15 are ignored in the second run, and both results match the model.
- r=20, b=31: clamped to r=16, b=16; output identical to the r=16, b=16 run.
- Assert start every cycle during a run, and toggle num_rounds and key: no restart; result is unchanged; exactly one done pulse.
- Drop rst at cycle 40 of an r=12 run: all outputs go to 0 immediately. Restart: correct table, and subkeys_valid is never seen high between the reset and the new done. With RC5_KEY_ZEROIZE_EN defined, done moves one cycle later and internal L/A/B read 0.
